equalize_lut_ctrl: RTL

//  Sequencer for the histogram-equalisation divider. On start, walks CDF memory

---
 rtl/equalize_lut_ctrl_pkg.sv | 26 ++
 rtl/equalize_lut_ctrl_div_watchdog.sv | 36 +++
 rtl/equalize_lut_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/equalize_lut_ctrl_pkg.sv
// Shared types and defaults for the histogram-equalisation LUT sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package equalize_lut_ctrl_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 64;

  // Sequencer states; encodings are shared with the divider and remap blocks.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_LAT   = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_WR    = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  // Width of a counter that must be able to hold the value t.
  function automatic int cnt_width(input int t);
    return (t < 2) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/equalize_lut_ctrl_div_watchdog.sv
// Divider watchdog: counts cycles spent waiting for a divider result.
// Latency: expired is combinational on the TIMEOUT-th enabled cycle.
// Backpressure: none; counter saturates once expired.
// Ports: clk, reset (async active-low), clear (zero the count),
//        count_en (one waiting cycle), expired (this is wait cycle TIMEOUT).
module equalize_lut_ctrl_div_watchdog
  import equalize_lut_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt;

  // cnt holds the number of enabled cycles already completed, so the
  // TIMEOUT-th waiting cycle is the one that sees cnt == TIMEOUT-1.
  assign expired = count_en && (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/equalize_lut_ctrl.sv
// Sequencer: CDF RAM -> divider -> equalisation LUT RAM, one entry at a time.
// Latency: 5 cycles/entry with a 1-cycle divider; start-to-done 5*2^ADDR_W+2 cycles inclusive.
// Backpressure: stalls in WAIT for div_ready; aborts with err after TIMEOUT cycles.
// Ports: start/busy/done/err run control; cdf_rd_* CDF read port (1-cycle read
//        latency); div_* divider handshake and operand; lut_wr_* LUT write port.
module equalize_lut_ctrl
  import equalize_lut_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cdf_rd_en,
  output logic [ADDR_W-1:0] cdf_rd_addr,
  input  logic [DATA_W-1:0] cdf_rd_data,
  output logic              div_enable,
  output logic [DATA_W-1:0] div_cdf_in,
  input  logic [DATA_W-1:0] div_g_out,
  input  logic              div_ready,
  output logic              lut_wr_en,
  output logic [ADDR_W-1:0] lut_wr_addr,
  output logic [DATA_W-1:0] lut_wr_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              wd_clear, wd_en, wd_expired;

  equalize_lut_ctrl_div_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_en),
    .expired  (wd_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RD;
          idx_nxt   = '0;
        end
      end
      S_RD:    state_nxt = S_LAT;
      S_LAT:   state_nxt = S_ISSUE;
      S_ISSUE: begin
        wd_clear  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Only WAIT looks at div_ready, so a ready left over from ISSUE is
        // never mistaken for this entry's result. Ready wins over expiry.
        wd_en = 1'b1;
        if (div_ready) begin
          state_nxt = S_WR;
        end else if (wd_expired) begin
          state_nxt = S_FIN;
        end
      end
      S_WR: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_FIN;
        end else begin
          idx_nxt   = idx + 1'b1;
          state_nxt = S_RD;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so each strobe is high exactly
  // while the FSM sits in its state, without any decode glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cdf_rd_en   <= 1'b0;
      cdf_rd_addr <= '0;
      div_enable  <= 1'b0;
      div_cdf_in  <= '0;
      lut_wr_en   <= 1'b0;
      lut_wr_addr <= '0;
      lut_wr_data <= '0;
    end else begin
      idx        <= idx_nxt;
      busy       <= (state_nxt != S_IDLE);
      done       <= (state_nxt == S_FIN);
      cdf_rd_en  <= (state_nxt == S_RD);
      div_enable <= (state_nxt == S_ISSUE);
      lut_wr_en  <= (state_nxt == S_WR);

      if (state == S_IDLE && start) begin
        err <= 1'b0;
      end else if (state == S_WAIT && state_nxt == S_FIN) begin
        err <= 1'b1;
      end

      if (state_nxt == S_RD) begin
        cdf_rd_addr <= idx_nxt;
      end
      // Read data arrives in LAT; the operand then holds until the next LAT.
      if (state == S_LAT) begin
        div_cdf_in <= cdf_rd_data;
      end
      if (state == S_WAIT && div_ready) begin
        lut_wr_addr <= idx;
        lut_wr_data <= div_g_out;
      end
    end
  end

endmodule
